// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module : bp_pkg
// Desc   : Shared tournament-predictor types and default sizes.
// Rev    : 1.0
// ============================================================================
package bp_pkg;

    localparam int BP_IDX_W  = 10;
    localparam int PRQ_DEPTH = 8;

    typedef enum logic {
        CHOICE_LOCAL  = 1'b0,
        CHOICE_GLOBAL = 1'b1
    } choice_e;

    typedef struct packed {
        logic                local_pred;
        logic                global_pred;
        choice_e             choice;
        logic [BP_IDX_W-1:0] idx;
    } prq_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : bp_sat_counter
// Desc   : Unsigned up-counter that sticks at all-ones.
// Rev    : 1.0
// ============================================================================
module bp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prediction_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module : prediction_resolve_queue
// Desc   : In-order queue of fetch-time predictions, scored at resolution.
//          Optional PRQ_STATS_EN adds saturating resolve/mispredict counters.
// Rev    : 1.0
// ============================================================================
module prediction_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = PRQ_DEPTH,
    parameter int IDX_W = BP_IDX_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_local_pred,
    input  logic                       alloc_global_pred,
    input  logic                       alloc_choice,
    input  logic [IDX_W-1:0]           alloc_idx,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       upd_valid,
    output logic                       upd_local_correct,
    output logic                       upd_global_correct,
    output logic                       upd_mispredict,
    output logic                       upd_choice,
    output logic [IDX_W-1:0]           upd_idx,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       resolve_err
`ifdef PRQ_STATS_EN
    ,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispredict
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    // The stored index is sized by the package; IDX_W must not exceed BP_IDX_W.
    prq_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;

    logic               w_push;
    logic               w_pop;
    logic               w_mis;
    logic [c_CNT_W-1:0] w_count_nxt;
    prq_entry_t         w_wr_entry;
    prq_entry_t         w_rd_entry;

    assign alloc_ready = !full;
    assign w_push      = alloc_valid && !full && !flush;
    assign w_pop       = resolve_valid && !empty;
    assign w_rd_entry  = r_mem[r_head];
    assign w_mis       = ((w_rd_entry.choice == CHOICE_GLOBAL) ? w_rd_entry.global_pred
                                                               : w_rd_entry.local_pred)
                         != resolve_taken;

    always_comb begin
        w_wr_entry             = '0;
        w_wr_entry.local_pred  = alloc_local_pred;
        w_wr_entry.global_pred = alloc_global_pred;
        w_wr_entry.choice      = choice_e'(alloc_choice);
        w_wr_entry.idx         = BP_IDX_W'(alloc_idx);
    end

    always_comb begin
        w_count_nxt = count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = count - c_CNT_W'(1);
        end
    end

    // Storage is not reset; only entries between head and tail are ever read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_tail] <= w_wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            count <= w_count_nxt;
            empty <= (w_count_nxt == '0);
            full  <= (w_count_nxt == c_CNT_W'(DEPTH));
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            // Flush collapses the queue onto the (unchanged) tail.
            if (flush) begin
                r_head <= r_tail;
            end else if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid          <= 1'b0;
            upd_local_correct  <= 1'b0;
            upd_global_correct <= 1'b0;
            upd_mispredict     <= 1'b0;
            upd_choice         <= 1'b0;
            upd_idx            <= '0;
            resolve_err        <= 1'b0;
        end else begin
            upd_valid <= w_pop;
            if (w_pop) begin
                upd_local_correct  <= (w_rd_entry.local_pred == resolve_taken);
                upd_global_correct <= (w_rd_entry.global_pred == resolve_taken);
                upd_mispredict     <= w_mis;
                upd_choice         <= w_rd_entry.choice;
                upd_idx            <= IDX_W'(w_rd_entry.idx);
            end
            if (resolve_valid && empty) begin
                resolve_err <= 1'b1;
            end
        end
    end

`ifdef PRQ_STATS_EN
    // Counters advance on the same edge that raises upd_valid.
    bp_sat_counter #(.W(16)) u_stat_resolved (
        .clock (clock),
        .reset (reset),
        .inc   (w_pop),
        .value (stat_resolved)
    );

    bp_sat_counter #(.W(16)) u_stat_mispredict (
        .clock (clock),
        .reset (reset),
        .inc   (w_pop && w_mis),
        .value (stat_mispredict)
    );
`endif

endmodule
`default_nettype wire
